fifo_rd_ctrl: RTL and testbench

- Read-side drain controller for the async FIFO, in the R_CLK domain.
- Watches the FIFO empty flag and pops one word per UART TX frame. Registers the popped word, presents it to the UART transmitter with a one-cycle valid strobe, then sequences the busy handshake.
- Enforces an optional inter-frame gap and flags transmitters that never go busy (timeout).

---
 rtl/fifo_rd_ctrl.sv | 129 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side drain controller for the async FIFO: pops one word per UART TX frame.
// Define FIFO_RD_CTRL_STATS_EN to add the FRAME_CNT / TIMEOUT_CNT statistics ports.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CNT_WIDTH    = 8,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_INC,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  TIMEOUT_ERR,
    output logic                  CTRL_BUSY
`ifdef FIFO_RD_CTRL_STATS_EN
    ,
    output logic [15:0]           FRAME_CNT,
    output logic [7:0]            TIMEOUT_CNT
`endif
);
    typedef enum logic [2:0] {IDLE, POP, WAIT_HI, WAIT_LO, GAP} state_t;

    localparam logic [CNT_WIDTH:0] TO_LIM  = (CNT_WIDTH+1)'(BUSY_TIMEOUT);
    localparam logic [CNT_WIDTH:0] GAP_LIM = (CNT_WIDTH+1)'(GAP_CYCLES);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH:0]   cnt_p1;
    logic [CNT_WIDTH:0]   cnt_p2;
    logic                 to_hit;

    // One extra bit on the comparisons so limits up to 2^CNT_WIDTH-1 never overflow.
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    assign cnt_p1  = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign cnt_p2  = {1'b0, cnt} + (CNT_WIDTH+1)'(2);
    // Fires on the edge where the count would reach BUSY_TIMEOUT-1, i.e. the
    // pulse lands BUSY_TIMEOUT cycles after the valid strobe.
    assign to_hit  = (state == WAIT_HI) && !TX_BUSY && (cnt_p2 >= TO_LIM);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            cnt           <= '0;
            TX_P_DATA     <= '0;
            FIFO_RD_INC   <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
            CTRL_BUSY     <= 1'b0;
        end else begin
            FIFO_RD_INC   <= 1'b0;
            TX_DATA_VALID <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ENABLE && !FIFO_EMPTY && !TX_BUSY) begin
                        state         <= POP;
                        TX_P_DATA     <= FIFO_RD_DATA;
                        FIFO_RD_INC   <= 1'b1;
                        TX_DATA_VALID <= 1'b1;
                        CTRL_BUSY     <= 1'b1;
                    end
                end
                POP: begin
                    state <= WAIT_HI;
                    cnt   <= '0;
                end
                WAIT_HI: begin
                    if (TX_BUSY) begin
                        state <= WAIT_LO;
                    end else if (to_hit) begin
                        TIMEOUT_ERR <= 1'b1;
                        state       <= GAP;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LO: begin
                    if (!TX_BUSY) begin
                        cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state     <= IDLE;
                            CTRL_BUSY <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (cnt_p1 >= GAP_LIM) begin
                        state     <= IDLE;
                        CTRL_BUSY <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    CTRL_BUSY <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_CTRL_STATS_EN
    logic frame_done;
    assign frame_done = (state == WAIT_LO) && !TX_BUSY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FRAME_CNT   <= '0;
            TIMEOUT_CNT <= '0;
        end else begin
            if (frame_done && !(&FRAME_CNT))
                FRAME_CNT <= FRAME_CNT + 16'd1;
            if (to_hit && !(&TIMEOUT_CNT))
                TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO + UART TX responder models and a data scoreboard.
module tb_fifo_rd_ctrl;
    localparam int DW  = 8;
    localparam int GAP = 3;
    localparam int TMO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          FIFO_EMPTY;
    logic [DW-1:0] FIFO_RD_DATA;
    logic          FIFO_RD_INC;
    logic          TX_BUSY;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_DATA_VALID;
    logic          TIMEOUT_ERR;
    logic          CTRL_BUSY;
`ifdef FIFO_RD_CTRL_STATS_EN
    logic [15:0]   FRAME_CNT;
    logic [7:0]    TIMEOUT_CNT;
`endif

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] e_data;
    int n_chk = 0, n_fail = 0;
    int cyc = 0, pops = 0, valids = 0, tos = 0;
    int fall_cyc = -1, valid_cyc = 0;
    int dly = 0, hold = 0, tx_len = 20;
    bit tx_resp = 1'b1, tx_force = 1'b0, gap_chk = 1'b0;
    bit prev_rd = 1'b0, prev_cb = 1'b0;

    fifo_rd_ctrl #(
        .DATA_WIDTH(DW), .CNT_WIDTH(8), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_RD_INC(FIFO_RD_INC), .TX_BUSY(TX_BUSY),
        .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
        .TIMEOUT_ERR(TIMEOUT_ERR), .CTRL_BUSY(CTRL_BUSY)
`ifdef FIFO_RD_CTRL_STATS_EN
        , .FRAME_CNT(FRAME_CNT), .TIMEOUT_CNT(TIMEOUT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge CLK); #1;
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !CTRL_BUSY && !TX_BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic wait_busy(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (TX_BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 1);
    endtask

    // Monitor first (outputs are stable at the falling edge), then the FIFO and TX models drive.
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            if (FIFO_RD_INC) begin
                chk("rd_inc_one_cycle", 32'(prev_rd), 0);
                chk("valid_with_pop", 32'(TX_DATA_VALID), 1);
                chk("pop_nonempty", 32'(fifo_q.size() > 0), 1);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
            end
            if (TX_DATA_VALID) begin
                valids++;
                e_data = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("tx_data", 32'(TX_P_DATA), 32'(e_data));
                if (gap_chk && fall_cyc >= 0) chk("busy_fall_to_pop", cyc - fall_cyc, GAP + 2);
                fall_cyc  = -1;
                valid_cyc = cyc;
            end
            if (TIMEOUT_ERR) begin
                tos++;
                chk("timeout_latency", cyc - valid_cyc, TMO);
            end
            if (gap_chk && prev_cb && !CTRL_BUSY && fall_cyc >= 0)
                chk("busy_fall_to_idle", cyc - fall_cyc, GAP + 1);
            prev_rd = FIFO_RD_INC;
            prev_cb = CTRL_BUSY;
            // TX responder: busy rises 2 cycles after valid and stays up tx_len cycles.
            if (hold > 0) begin
                hold--;
                if (hold == 0) fall_cyc = cyc;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) hold = tx_len;
            end
            if (TX_DATA_VALID && tx_resp) dly = 2;
        end else begin
            dly = 0; hold = 0; prev_rd = 1'b0; prev_cb = 1'b0; fall_cyc = -1;
        end
        TX_BUSY      = tx_force || (hold > 0);
        FIFO_EMPTY   = (fifo_q.size() == 0);
        FIFO_RD_DATA = FIFO_EMPTY ? 8'h00 : fifo_q[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        ENABLE = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rd_inc", 32'(FIFO_RD_INC), 0);
        chk("rst_valid", 32'(TX_DATA_VALID), 0);
        chk("rst_ctrl_busy", 32'(CTRL_BUSY), 0);
        chk("rst_timeout", 32'(TIMEOUT_ERR), 0);
        chk("rst_tx_data", 32'(TX_P_DATA), 0);
        RST = 1'b1;

        // Empty FIFO, enabled: nothing happens.
        repeat (50) @(posedge CLK);
        #1;
        chk("idle_pops", pops, 0);
        chk("idle_ctrl_busy", 32'(CTRL_BUSY), 0);
        chk("idle_tx_data", 32'(TX_P_DATA), 0);

        // Single frame.
        push(8'hA5);
        wait_done("single_done", 200);
        chk("single_pops", pops, 1);
        chk("single_valids", valids, 1);
        chk("single_tx_hold", 32'(TX_P_DATA), 32'h A5);

        // Burst with inter-frame gap.
        gap_chk = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        wait_done("burst_done", 400);
        gap_chk = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("burst_pops", pops, 4);
        chk("burst_last_data", 32'(TX_P_DATA), 32'h03);

        // TX busy already high: hold off until it falls.
        tx_force = 1'b1;
        push(8'h77);
        repeat (30) @(posedge CLK);
        #1;
        chk("busy_hold_pops", pops, 4);
        chk("busy_hold_ctrl", 32'(CTRL_BUSY), 0);
        tx_force = 1'b0;
        wait_done("busy_release_done", 200);
        chk("busy_release_pops", pops, 5);

        // Timeout: transmitter never goes busy.
        tx_resp = 1'b0;
        push(8'h3C); push(8'h4D);
        for (int i = 0; i < 200 && tos < 2; i++) begin
            @(posedge CLK); #1;
        end
        wait_done("timeout_done", 100);
        chk("timeout_count", tos, 2);
        chk("timeout_pops", pops, 7);
`ifdef FIFO_RD_CTRL_STATS_EN
        chk("stats_timeout_cnt", 32'(TIMEOUT_CNT), 2);
        chk("stats_frame_cnt", 32'(FRAME_CNT), 5);
`endif
        tx_resp = 1'b1;

        // ENABLE dropped mid-frame.
        push(8'h11); push(8'h22); push(8'h33);
        wait_busy("en_wait_busy");
        ENABLE = 1'b0;
        repeat (60) @(posedge CLK);
        #1;
        chk("en_off_pops", pops, 8);
        chk("en_off_left", exp_q.size(), 2);
        chk("en_off_ctrl", 32'(CTRL_BUSY), 0);
        ENABLE = 1'b1;
        wait_done("en_on_done", 300);
        chk("en_on_pops", pops, 10);

        // Reset mid-frame: outputs clear asynchronously.
        push(8'h44); push(8'h55);
        wait_busy("rst_wait_busy");
        RST = 1'b0;
        #1;
        chk("midrst_rd_inc", 32'(FIFO_RD_INC), 0);
        chk("midrst_valid", 32'(TX_DATA_VALID), 0);
        chk("midrst_ctrl_busy", 32'(CTRL_BUSY), 0);
        chk("midrst_timeout", 32'(TIMEOUT_ERR), 0);
        chk("midrst_tx_data", 32'(TX_P_DATA), 0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        wait_done("post_rst_done", 200);
        chk("post_rst_pops", pops, 12);
        chk("post_rst_data", 32'(TX_P_DATA), 32'h55);
`ifdef FIFO_RD_CTRL_STATS_EN
        chk("stats_frame_after_rst", 32'(FRAME_CNT), 1);
        chk("stats_to_after_rst", 32'(TIMEOUT_CNT), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
